uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte sources, e.g. parallel LFSR PRNG streams.
- Grants one requester at a time and latches its byte and parity mode.
- Runs the transmitter's ready/valid handshake: raise ready, wait for valid, drop ready, wait for valid to clear.
- Returns a one-cycle acknowledge to the granted source.

---
 rtl/uart_sched_pkg.sv | 31 +++
 rtl/rr_arb.sv | 23 ++
 rtl/uart_tx_sched.sv | 122 ++++++++++++
 tb/tb_uart_tx_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: state codes, the
// header tag byte prefix and the round-robin winner search.
package uart_sched_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_HDR   = 3'd4;

  localparam logic [4:0] HDR_TAG  = 5'b10100;
  localparam int         MAX_REQ  = 8;

  // First set bit searching upward from ptr+1 with wrap over n requesters.
  // Walking k downward lets the nearest candidate overwrite farther ones.
  function automatic logic [2:0] first_set_rr(input logic [MAX_REQ-1:0] req,
                                              input logic [2:0] ptr,
                                              input int n);
    logic [2:0] win;
    int         idx;
    win = 3'd0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx]) win = 3'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: winner after ptr, as index and one-hot.
module rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);
  import uart_sched_pkg::*;

  logic [MAX_REQ-1:0] req_pad;
  logic [2:0]         win;

  assign req_pad      = MAX_REQ'(req);
  assign win          = first_set_rr(req_pad, 3'(ptr), NUM_REQ);
  assign any_req      = |req;
  assign grant_idx    = ID_W'(win);
  assign grant_onehot = any_req ? (NUM_REQ'(1) << win) : '0;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// sources. Latches byte + parity mode at grant, runs the transmitter's
// ready/valid handshake and pulses req_ack once the frame is out.
// Optional: define UART_SCHED_ID_HEADER_EN to prefix every grant with a
// header frame {HDR_TAG, grant_id[2:0]} carrying the same parity mode.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic                 clk,
  input  logic                 ap_rstn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 par_en,
  output logic                 ut_ready,
  input  logic                 ut_valid,
  output logic [7:0]           ut_data,
  output logic                 ut_pairty,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);
  import uart_sched_pkg::*;

  logic [2:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, arb_idx;
  logic [NUM_REQ-1:0] arb_onehot;
  logic               arb_any;
  logic               grant_go;
  logic               hdr_more;
  logic [7:0]         sel_byte;

  rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req          (req),
    .ptr          (ptr_q),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .any_req      (arb_any)
  );

  // One-hot mux of the winning source's byte
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_onehot[i]) sel_byte = sel_byte | req_data[8*i +: 8];
  end

  // A stale ut_valid in IDLE blocks the grant until the transmitter is idle
  assign grant_go = (state_q == ST_IDLE) && arb_any && !ut_valid;

`ifdef UART_SCHED_ID_HEADER_EN
  logic       hdr_q;
  logic [7:0] pay_q;

  assign hdr_more = hdr_q;

  // Header flag and parked payload byte; cleared once the header drains
  always_ff @(posedge clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      hdr_q <= 1'b0;
      pay_q <= '0;
    end else if (grant_go) begin
      hdr_q <= 1'b1;
      pay_q <= sel_byte;
    end else if (state_q == ST_DRAIN && !ut_valid) begin
      hdr_q <= 1'b0;
    end
  end
`else
  assign hdr_more = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge ap_rstn) begin
    if (!ap_rstn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a drained header loops back to SEND for the payload
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_go) state_d = ST_SEND;
      ST_SEND:  if (ut_valid) state_d = ST_DRAIN;
      ST_DRAIN: if (!ut_valid) state_d = hdr_more ? ST_SEND : ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant-time latches; frame data only changes between frames
  always_ff @(posedge clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      ptr_q     <= ID_W'(NUM_REQ - 1);
      grant_id  <= '0;
      ut_pairty <= 1'b0;
      ut_data   <= '0;
    end else if (grant_go) begin
      ptr_q     <= arb_idx;
      grant_id  <= arb_idx;
      ut_pairty <= par_en;
`ifdef UART_SCHED_ID_HEADER_EN
      ut_data   <= {HDR_TAG, 3'(arb_idx)};
`else
      ut_data   <= sel_byte;
`endif
    end
`ifdef UART_SCHED_ID_HEADER_EN
    else if (state_q == ST_DRAIN && !ut_valid && hdr_q) begin
      ut_data   <= pay_q;
    end
`endif
  end

  // State-decoded outputs
  always_comb begin
    ut_ready = (state_q == ST_SEND);
    busy     = (state_q != ST_IDLE);
    req_ack  = (state_q == ST_ACK) ? (NUM_REQ'(1) << grant_id) : '0;
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched. A behavioural transmitter answers the
// ready/valid handshake and reports each completed frame; an ack monitor
// reports req_ack pulses. Both pop expectations pushed by the stimulus.
module tb_uart_tx_sched;
  import uart_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 3;
  localparam int FRAME   = 11;

  logic                 clk = 1'b0;
  logic                 ap_rstn = 1'b0;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 par_en = 1'b0;
  logic                 ut_ready;
  logic                 ut_valid = 1'b0;
  logic [7:0]           ut_data;
  logic                 ut_pairty;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;

  int vec_cnt = 0;
  int err_cnt = 0;

  int want [NUM_REQ] = '{default: 0};
  int done [NUM_REQ] = '{default: 0};

  logic [8:0]         exp_frame [$];
  logic [NUM_REQ-1:0] exp_ack   [$];

  always #5 clk = ~clk;

  // A source requests while it still has bytes it wants served
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req[i] = (want[i] != done[i]);
  end

  uart_tx_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .ap_rstn   (ap_rstn),
    .req       (req),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .par_en    (par_en),
    .ut_ready  (ut_ready),
    .ut_valid  (ut_valid),
    .ut_data   (ut_data),
    .ut_pairty (ut_pairty),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int src, input logic [7:0] d, input logic p);
`ifdef UART_SCHED_ID_HEADER_EN
    exp_frame.push_back({p, HDR_TAG, 3'(src)});
`endif
    exp_frame.push_back({p, d});
    exp_ack.push_back(NUM_REQ'(1) << src);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (exp_frame.size() == 0 && exp_ack.size() == 0 && !busy && req == '0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_complete"}, 32'(ok), 32'd1);
  endtask

  // Behavioural transmitter: accepts on ready, holds valid for FRAME cycles
  logic       tx_busy = 1'b0;
  int         tx_cnt  = 0;
  logic [7:0] cap_d;
  logic       cap_p;
  logic       stable;
  logic [8:0] e_frm;
  always @(negedge clk) begin
    if (!ap_rstn) begin
      ut_valid = 1'b0;
      tx_busy  = 1'b0;
      tx_cnt   = 0;
    end else if (!tx_busy) begin
      if (ut_ready) begin
        tx_busy  = 1'b1;
        cap_d    = ut_data;
        cap_p    = ut_pairty;
        stable   = 1'b1;
        tx_cnt   = 0;
        ut_valid = 1'b1;
      end
    end else begin
      tx_cnt++;
      if (ut_data !== cap_d || ut_pairty !== cap_p) stable = 1'b0;
      if (tx_cnt == FRAME) begin
        ut_valid = 1'b0;
        tx_busy  = 1'b0;
        check("frame_stable", 32'(stable), 32'd1);
        if (exp_frame.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL frame_unexpected: got %0h expected none", {cap_p, cap_d});
        end else begin
          e_frm = exp_frame.pop_front();
          check("frame", 32'({cap_p, cap_d}), 32'(e_frm));
        end
      end
    end
  end

  // Ack monitor
  logic [NUM_REQ-1:0] e_ack;
  always @(negedge clk) begin
    if (ap_rstn && req_ack != '0) begin
      if (exp_ack.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL ack_unexpected: got %0h expected none", req_ack);
      end else begin
        e_ack = exp_ack.pop_front();
        check("ack", 32'(req_ack), 32'(e_ack));
      end
      for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) done[i]++;
    end
  end

  initial begin : stim
    bit hit;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ut_ready", 32'(ut_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_ut_data", 32'(ut_data), 32'd0);
    check("rst_ut_pairty", 32'(ut_pairty), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    ap_rstn = 1'b1;
    @(negedge clk);

    // Single request, one-cycle grant latency
    req_data[7:0] = 8'h5A;
    par_en        = 1'b0;
    expect_grant(0, 8'h5A, 1'b0);
    want[0]++;
    @(negedge clk);
    check("grant_latency", 32'({busy, ut_ready}), 32'b11);
    check("grant_id_single", 32'(grant_id), 32'd0);
    wait_idle("single");
    check("busy_after_ack", 32'(busy), 32'd0);

    // Fairness from reset pointer: 0,1,2,3 then 0 again
    ap_rstn = 1'b0;
    @(negedge clk);
    ap_rstn  = 1'b1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    expect_grant(0, 8'h10, 1'b0);
    expect_grant(1, 8'h11, 1'b0);
    expect_grant(2, 8'h12, 1'b0);
    expect_grant(3, 8'h13, 1'b0);
    expect_grant(0, 8'h10, 1'b0);
    want[0] += 2;
    want[1]++;
    want[2]++;
    want[3]++;
    wait_idle("fairness");

    // Parity mode latched at grant survives par_en dropping
    req_data[23:16] = 8'h07;
    par_en          = 1'b1;
    expect_grant(2, 8'h07, 1'b1);
    want[2]++;
    @(negedge clk);
    par_en = 1'b0;
    repeat (4) @(negedge clk);
    check("parity_hold", 32'(ut_pairty), 32'd1);
    wait_idle("parity");

    // Data stability while the source byte churns
    req_data[15:8] = 8'hC5;
    expect_grant(1, 8'hC5, 1'b0);
    want[1]++;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      req_data = {$urandom, $urandom} ^ 32'h5A5A_A5A5;
      @(negedge clk);
    end
    wait_idle("stability");

    // Reset mid-frame: source 3 (after ptr=1) aborted, then 1 and 3 re-served
    req_data[15:8]  = 8'h96;
    req_data[31:24] = 8'h3C;
    want[1]++;
    want[3]++;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_busy && tx_cnt == 4) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_mid_frame", 32'(hit), 32'd1);
    check("pre_rst_grant", 32'(grant_id), 32'd3);
    ap_rstn = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ut_ready), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_valid", 32'(ut_valid), 32'd0);
    expect_grant(1, 8'h96, 1'b0);
    expect_grant(3, 8'h3C, 1'b0);
    ap_rstn = 1'b1;
    @(negedge clk);
    check("regrant_id", 32'(grant_id), 32'd1);
    wait_idle("reset_regrant");

    // Header vector (header frame only when the feature is built in)
    req_data[23:16] = 8'hC3;
    expect_grant(2, 8'hC3, 1'b0);
    want[2]++;
    wait_idle("header");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
